// File: rtl/seg_scan.sv
// seg_scan: six-digit multiplexed seven-segment scanner.
// A prescaler sets how long each digit position stays lit. The incoming
// digits are captured into shadow registers once per full scan, so a
// frame never mixes old and new values. The digit enables, segments and
// decimal point are registered and lag the position counter by one clock.
module seg_scan #(
  parameter int DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       y0,
  input  logic [3:0] y1,
  input  logic [3:0] y2,
  input  logic [3:0] y3,
  input  logic [3:0] y4,
  input  logic [3:0] y5,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pos_q, pos_d;
  logic          s0_q, s0_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d, s5_q, s5_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          load;
  logic [3:0]    digit;

  // Active-low {g,f,e,d,c,b,a} pattern; codes above 9 show a dash.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b0111111;
    endcase
  endfunction

  // Next-state logic: prescaler, position, shadow capture and output decode.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    load  = tick && (pos_q == 3'd5);
    cnt_d = tick ? '0 : cnt_q + 1'b1;

    pos_d = pos_q;
    if (tick) pos_d = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;

    s0_d = load ? y0 : s0_q;
    s1_d = load ? y1 : s1_q;
    s2_d = load ? y2 : s2_q;
    s3_d = load ? y3 : s3_q;
    s4_d = load ? y4 : s4_q;
    s5_d = load ? y5 : s5_q;
    frame_d = load;

    // Outputs decode from the current position and shadow contents,
    // never from the live inputs.
    digit = 4'd0;
    an_d  = 6'b111111;
    case (pos_q)
      3'd0: begin digit = {3'b000, s0_q}; an_d = 6'b011111; end
      3'd1: begin digit = s1_q;           an_d = 6'b101111; end
      3'd2: begin digit = s2_q;           an_d = 6'b110111; end
      3'd3: begin digit = s3_q;           an_d = 6'b111011; end
      3'd4: begin digit = s4_q;           an_d = 6'b111101; end
      3'd5: begin digit = s5_q;           an_d = 6'b111110; end
      default: begin digit = 4'd0;        an_d = 6'b111111; end
    endcase
    seg_d = enc(digit);
    dp_d  = (pos_q != 3'd0);
  end

  // State and registered outputs; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pos_q   <= 3'd0;
      s0_q    <= 1'b0;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      s3_q    <= 4'd0;
      s4_q    <= 4'd0;
      s5_q    <= 4'd0;
      an_q    <= 6'b111111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      s4_q    <= s4_d;
      s5_q    <= s5_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan with DIV=4 (24 clocks per frame).
// k counts rising edges since the last reset release; outputs are sampled
// on the falling edge that follows edge k.
module tb_seg_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       y0  = 1'b0;
  logic [3:0] y1  = 4'd0;
  logic [3:0] y2  = 4'd0;
  logic [3:0] y3  = 4'd0;
  logic [3:0] y4  = 4'd0;
  logic [3:0] y5  = 4'd0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  logic [5:0] exp_an  [6];
  logic [6:0] f1_seg  [6];
  logic [6:0] f2_seg  [6];

  seg_scan #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic adv();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (an !== 6'b111111) begin n_fail++; $display("FAIL reset_an got=%b want=111111", an); end
    n_checks++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg got=%b want=1111111", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b want=1", dp); end
    n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got=%b want=0", frame); end
    $display("test_reset done");
  endtask

  // Frame 0 after release shows the all-zero shadow; pulse after edge 24.
  task automatic test_first_frame();
    int p;
    y0 = 1'b1; y1 = 4'd2; y2 = 4'd5; y3 = 4'd0; y4 = 4'd9; y5 = 4'd7;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 24; i++) begin
      adv();
      p = ((k - 1) / 4) % 6;
      n_checks++; if (an !== exp_an[p]) begin n_fail++; $display("FAIL f0_an k=%0d got=%b want=%b", k, an, exp_an[p]); end
      n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL f0_seg k=%0d got=%b want=1000000", k, seg); end
      n_checks++; if (dp !== ((p == 0) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL f0_dp k=%0d got=%b pos=%0d", k, dp, p); end
      n_checks++; if (frame !== ((k == 24) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL f0_frame k=%0d got=%b", k, frame); end
    end
    $display("test_first_frame done k=%0d", k);
  endtask

  // Frame 1 shows 1.2509 / 7; inputs changed mid-frame must not appear.
  task automatic test_no_tear();
    int p;
    for (int i = 0; i < 24; i++) begin
      adv();
      p = ((k - 1) / 4) % 6;
      n_checks++; if (an !== exp_an[p]) begin n_fail++; $display("FAIL f1_an k=%0d got=%b want=%b", k, an, exp_an[p]); end
      n_checks++; if (seg !== f1_seg[p]) begin n_fail++; $display("FAIL f1_seg k=%0d got=%b want=%b", k, seg, f1_seg[p]); end
      n_checks++; if (dp !== ((p == 0) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL f1_dp k=%0d got=%b pos=%0d", k, dp, p); end
      n_checks++; if (frame !== ((k == 48) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL f1_frame k=%0d got=%b", k, frame); end
      if (k == 33) begin
        y3 = 4'd4;
        y2 = 4'd12;
      end
    end
    $display("test_no_tear done k=%0d", k);
  endtask

  // Frame 2 picks up y3=4 and the out-of-range y2=12 (dash, dp dark).
  task automatic test_dash();
    int p;
    for (int i = 0; i < 24; i++) begin
      adv();
      p = ((k - 1) / 4) % 6;
      n_checks++; if (an !== exp_an[p]) begin n_fail++; $display("FAIL f2_an k=%0d got=%b want=%b", k, an, exp_an[p]); end
      n_checks++; if (seg !== f2_seg[p]) begin n_fail++; $display("FAIL f2_seg k=%0d got=%b want=%b", k, seg, f2_seg[p]); end
      n_checks++; if (dp !== ((p == 0) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL f2_dp k=%0d got=%b pos=%0d", k, dp, p); end
    end
    $display("test_dash done k=%0d", k);
  endtask

  // Constant inputs: frames repeat identically, pulses 24 clocks apart.
  task automatic test_frame_period();
    int p;
    int last;
    int pulses;
    last = 72;
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      adv();
      p = ((k - 1) / 4) % 6;
      n_checks++; if (an !== exp_an[p]) begin n_fail++; $display("FAIL fp_an k=%0d got=%b want=%b", k, an, exp_an[p]); end
      n_checks++; if (seg !== f2_seg[p]) begin n_fail++; $display("FAIL fp_seg k=%0d got=%b want=%b", k, seg, f2_seg[p]); end
      if (frame === 1'b1) begin
        pulses++;
        n_checks++; if (k - last !== 24) begin n_fail++; $display("FAIL fp_gap k=%0d got=%0d want=24", k, k - last); end
        last = k;
      end
    end
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL fp_pulses got=%0d want=2", pulses); end
    $display("test_frame_period done k=%0d", k);
  endtask

  // Reset between edges at pos=3 blanks at once; restart matches power-up.
  task automatic test_async_reset();
    while (k < 132) adv();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (an !== 6'b111111) begin n_fail++; $display("FAIL ar_an got=%b want=111111", an); end
    n_checks++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL ar_seg got=%b want=1111111", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL ar_dp got=%b want=1", dp); end
    n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL ar_frame got=%b want=0", frame); end
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    adv();
    n_checks++; if (an !== 6'b011111) begin n_fail++; $display("FAIL ar1_an got=%b want=011111", an); end
    n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL ar1_seg got=%b want=1000000", seg); end
    n_checks++; if (dp !== 1'b0) begin n_fail++; $display("FAIL ar1_dp got=%b want=0", dp); end
    while (k < 23) adv();
    n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL ar_frame23 got=%b want=0", frame); end
    n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL ar_seg23 got=%b want=1000000", seg); end
    adv();
    n_checks++; if (frame !== 1'b1) begin n_fail++; $display("FAIL ar_frame24 got=%b want=1", frame); end
    adv();
    n_checks++; if (seg !== 7'b1111001) begin n_fail++; $display("FAIL ar_seg25 got=%b want=1111001", seg); end
    n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL ar_frame25 got=%b want=0", frame); end
    $display("test_async_reset done k=%0d", k);
  endtask

  initial begin
    exp_an[0] = 6'b011111; exp_an[1] = 6'b101111; exp_an[2] = 6'b110111;
    exp_an[3] = 6'b111011; exp_an[4] = 6'b111101; exp_an[5] = 6'b111110;
    f1_seg[0] = 7'b1111001; f1_seg[1] = 7'b0100100; f1_seg[2] = 7'b0010010;
    f1_seg[3] = 7'b1000000; f1_seg[4] = 7'b0010000; f1_seg[5] = 7'b1111000;
    f2_seg[0] = 7'b1111001; f2_seg[1] = 7'b0100100; f2_seg[2] = 7'b0111111;
    f2_seg[3] = 7'b0011001; f2_seg[4] = 7'b0010000; f2_seg[5] = 7'b1111000;

    test_reset();
    test_first_frame();
    test_no_tear();
    test_dash();
    test_frame_period();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
